// File: rtl/timer_bank_pkg.sv
// Shared definitions for the timer bank: register map, control bits,
// channel state encoding and prescaler select decoding.
package timer_bank_pkg;

    // Per-channel register offsets (low nibble of the channel-relative address)
    localparam logic [3:0] OFF_CTRL      = 4'd0;
    localparam logic [3:0] OFF_STATUS    = 4'd1;
    // Upper two offset bits select the multi-byte register group
    localparam logic [1:0] OFF_RELOAD_HI  = 2'b01;
    localparam logic [1:0] OFF_COMPARE_HI = 2'b10;
    localparam logic [1:0] OFF_COUNT_HI   = 2'b11;

    // CTRL bit positions
    localparam int CTRL_GO     = 0;
    localparam int CTRL_EN     = 1;
    localparam int CTRL_AUTO   = 2;
    localparam int CTRL_PWM_EN = 3;
    localparam int CTRL_IE     = 4;
    localparam int CTRL_PS_LSB = 5;

    // STATUS bit positions
    localparam int STATUS_INT = 0;

    // Shared prescaler width and the "every cycle" prescaler select
    localparam int         PSC_W   = 7;
    localparam logic [2:0] PS_DIV1 = 3'd0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

    // A channel ticks when the low ps bits of the prescaler are all ones,
    // which divides the clock by 2^ps; ps=0 ticks every cycle.
    function automatic logic ps_tick(input logic [PSC_W-1:0] psc, input logic [2:0] ps);
        logic [PSC_W-1:0] mask;
        mask = ~({PSC_W{1'b1}} << ps);
        return (ps == PS_DIV1) || ((psc & mask) == mask);
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: control/reload/compare registers, up-counter with
// IDLE/RUN state machine, shadowed compare, registered PWM and sticky INT.
module timer_channel
    import timer_bank_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 tick_i,
    input  logic                 ctrl_we_i,
    input  logic                 sts_we_i,
    input  logic [CNT_W/8-1:0]   reload_we_i,
    input  logic [CNT_W/8-1:0]   cmp_we_i,
    input  logic [7:0]           wdata_i,
    output logic [7:0]           ctrl_o,
    output logic                 int_o,
    output logic [31:0]          reload_o,
    output logic [31:0]          compare_o,
    output logic [31:0]          count_o,
    output logic                 pwm_o
);

    localparam int NB = CNT_W / 8;

    logic [7:0]       ctrl_q, ctrl_d;
    logic             int_q, int_d;
    logic [CNT_W-1:0] reload_q, reload_d;
    logic [CNT_W-1:0] compare_q, compare_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    ch_state_e        state_q, state_d;
    logic             pwm_q, pwm_d;
    logic             hw_int;

    // Next-state: register writes, run/stop control, counting and rollover
    always_comb begin
        ctrl_d    = ctrl_q;
        reload_d  = reload_q;
        compare_d = compare_q;
        count_d   = count_q;
        shadow_d  = shadow_q;
        state_d   = state_q;
        hw_int    = 1'b0;

        for (int b = 0; b < NB; b++) begin
            if (reload_we_i[b]) reload_d[b*8 +: 8] = wdata_i;
            if (cmp_we_i[b])    compare_d[b*8 +: 8] = wdata_i;
        end

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q[CTRL_EN] && ctrl_q[CTRL_GO]) begin
                    count_d  = reload_q;
                    shadow_d = compare_q;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!ctrl_q[CTRL_EN] || !ctrl_q[CTRL_GO]) begin
                    state_d = ST_IDLE;
                end else if (tick_i) begin
                    if (&count_q) begin
                        hw_int   = 1'b1;
                        count_d  = reload_q;
                        shadow_d = compare_q;
                        if (!ctrl_q[CTRL_AUTO]) begin
                            ctrl_d[CTRL_GO] = 1'b0;
                            state_d         = ST_IDLE;
                        end
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!ctrl_q[CTRL_EN]) ctrl_d[CTRL_GO] = 1'b0;
        // A software CTRL write overrides any hardware GO clear this cycle
        if (ctrl_we_i) ctrl_d = wdata_i;

        // Hardware set beats a same-cycle write-1-to-clear
        int_d = int_q;
        if (sts_we_i && wdata_i[STATUS_INT]) int_d = 1'b0;
        if (hw_int) int_d = 1'b1;

        // PWM is computed from next-state values so it lines up with count_q
        pwm_d = (state_d == ST_RUN) && ctrl_d[CTRL_PWM_EN] && (count_d < shadow_d);
    end

    // State register
    always_ff @(posedge clk_in) begin
        if (rst) begin
            ctrl_q    <= '0;
            int_q     <= 1'b0;
            reload_q  <= '0;
            compare_q <= '0;
            count_q   <= '0;
            shadow_q  <= '0;
            state_q   <= ST_IDLE;
            pwm_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            int_q     <= int_d;
            reload_q  <= reload_d;
            compare_q <= compare_d;
            count_q   <= count_d;
            shadow_q  <= shadow_d;
            state_q   <= state_d;
            pwm_q     <= pwm_d;
        end
    end

    // Zero-extend the multi-byte registers to a full 32-bit read view
    always_comb begin
        reload_o  = '0;
        compare_o = '0;
        count_o   = '0;
        reload_o[CNT_W-1:0]  = reload_q;
        compare_o[CNT_W-1:0] = compare_q;
        count_o[CNT_W-1:0]   = count_q;
    end

    assign ctrl_o = ctrl_q;
    assign int_o  = int_q;
    assign pwm_o  = pwm_q;

endmodule

// File: rtl/timer_bank.sv
// Bank of N_CH timer channels sharing one free-running prescaler, with a
// byte-wide register bus (address decode and registered read mux).
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int         N_CH  = 2,
    parameter int         CNT_W = 16,
    parameter logic [7:0] BASE  = 8'h00
) (
    input  logic            clk_in,
    input  logic            rst,
    input  logic [7:0]      address,
    input  logic [7:0]      wdata,
    input  logic            wen,
    input  logic            ren,
    output logic [7:0]      rdata,
    output logic [N_CH-1:0] pwm_out,
    output logic            irq
);

    localparam int NB = CNT_W / 8;

    logic [PSC_W-1:0] psc_q;
    logic [8:0]       rel_full;
    logic [7:0]       rel;
    logic             in_range;
    logic [1:0]       sel_ch;
    logic [3:0]       off;
    logic [7:0]       rd_d;
    logic [7:0]       rdata_q;

    logic [7:0]       ch_ctrl   [N_CH];
    logic [31:0]      ch_reload [N_CH];
    logic [31:0]      ch_cmp    [N_CH];
    logic [31:0]      ch_count  [N_CH];
    logic [N_CH-1:0]  ch_int;
    logic [N_CH-1:0]  irq_vec;

    // Channel-relative address; a borrow means the address is below BASE
    assign rel_full = {1'b0, address} - {1'b0, BASE};
    assign rel      = rel_full[7:0];
    assign in_range = !rel_full[8] && (rel < 8'(16 * N_CH));
    assign sel_ch   = rel[5:4];
    assign off      = rel[3:0];

    // Shared prescaler free-runs; only reset clears it
    always_ff @(posedge clk_in) begin
        if (rst) psc_q <= '0;
        else     psc_q <= psc_q + 1'b1;
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic          hit;
            logic          tick;
            logic          ctrl_we;
            logic          sts_we;
            logic [NB-1:0] reload_we;
            logic [NB-1:0] cmp_we;

            assign hit       = wen && in_range && (sel_ch == 2'(gi));
            assign ctrl_we   = hit && (off == OFF_CTRL);
            assign sts_we    = hit && (off == OFF_STATUS);
            // Byte lanes beyond the counter width fall off the cast and are ignored
            assign reload_we = {NB{hit && (off[3:2] == OFF_RELOAD_HI)}}  & NB'(4'b0001 << off[1:0]);
            assign cmp_we    = {NB{hit && (off[3:2] == OFF_COMPARE_HI)}} & NB'(4'b0001 << off[1:0]);
            assign tick      = ps_tick(psc_q, ch_ctrl[gi][CTRL_PS_LSB +: 3]);
            assign irq_vec[gi] = ch_int[gi] & ch_ctrl[gi][CTRL_IE];

            timer_channel #(
                .CNT_W (CNT_W)
            ) u_channel (
                .clk_in      (clk_in),
                .rst         (rst),
                .tick_i      (tick),
                .ctrl_we_i   (ctrl_we),
                .sts_we_i    (sts_we),
                .reload_we_i (reload_we),
                .cmp_we_i    (cmp_we),
                .wdata_i     (wdata),
                .ctrl_o      (ch_ctrl[gi]),
                .int_o       (ch_int[gi]),
                .reload_o    (ch_reload[gi]),
                .compare_o   (ch_cmp[gi]),
                .count_o     (ch_count[gi]),
                .pwm_o       (pwm_out[gi])
            );
        end
    endgenerate

    // Read mux: unmapped addresses and offsets return zero
    always_comb begin
        rd_d = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (in_range && (sel_ch == 2'(c))) begin
                if (off == OFF_CTRL)                  rd_d = ch_ctrl[c];
                else if (off == OFF_STATUS)           rd_d[STATUS_INT] = ch_int[c];
                else if (off[3:2] == OFF_RELOAD_HI)   rd_d = ch_reload[c][{off[1:0], 3'b000} +: 8];
                else if (off[3:2] == OFF_COMPARE_HI)  rd_d = ch_cmp[c][{off[1:0], 3'b000} +: 8];
                else if (off[3:2] == OFF_COUNT_HI)    rd_d = ch_count[c][{off[1:0], 3'b000} +: 8];
            end
        end
    end

    // Read data register captures on ren and holds otherwise
    always_ff @(posedge clk_in) begin
        if (rst)      rdata_q <= '0;
        else if (ren) rdata_q <= rd_d;
    end

    assign rdata = rdata_q;
    assign irq   = |irq_vec;

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: two 16-bit channels at BASE 0.
module tb_timer_bank;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] address = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic       wen = 1'b0;
    logic       ren = 1'b0;
    logic [7:0] rdata;
    logic [1:0] pwm_out;
    logic       irq;

    int n_assert = 0;
    int n_fail = 0;
    int t_ff = -1;
    int t_fe2 = -1;
    logic [7:0] v;

    timer_bank #(
        .N_CH  (2),
        .CNT_W (16),
        .BASE  (8'h00)
    ) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .address (address),
        .wdata   (wdata),
        .wen     (wen),
        .ren     (ren),
        .rdata   (rdata),
        .pwm_out (pwm_out),
        .irq     (irq)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        address = a;
        wdata   = d;
        wen     = 1'b1;
        @(posedge clk_in);
        #1;
        wen = 1'b0;
        $display("write addr=%h data=%h", a, d);
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        address = a;
        ren     = 1'b1;
        @(posedge clk_in);
        #1;
        ren = 1'b0;
        d   = rdata;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
            $display("check %s observed=%h expected=%h ok", tag, obs, exp);
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rdchk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] d;
        rd(a, d);
        chk(tag, {24'h0, d}, {24'h0, exp});
    endtask

    initial begin
        // ---- reset state ----
        step(3);
        chk("rst_rdata", {24'h0, rdata}, 32'h0);
        chk("rst_pwm", {30'h0, pwm_out}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        rst = 1'b0;
        rdchk("rst_ctrl0", 8'h00, 8'h00);
        rdchk("rst_count0", 8'h0C, 8'h00);

        // ---- one-shot on channel 0: RELOAD=FFFA, CTRL=13 ----
        wr(8'h04, 8'hFA);
        wr(8'h05, 8'hFF);
        wr(8'h00, 8'h13);
        step(6);
        chk("oneshot_irq_before", {31'h0, irq}, 32'h0);
        step(1);
        chk("oneshot_irq_set", {31'h0, irq}, 32'h1);
        rdchk("oneshot_go_clear", 8'h00, 8'h12);
        rdchk("oneshot_status", 8'h01, 8'h01);
        rdchk("oneshot_count_lo", 8'h0C, 8'hFA);
        wr(8'h06, 8'h55);
        rdchk("reload_byte2_zero", 8'h06, 8'h00);
        rdchk("unmapped_off2", 8'h02, 8'h00);
        rdchk("unmapped_ch2", 8'h20, 8'h00);
        rdchk("unmapped_ff", 8'hFF, 8'h00);
        rdchk("oneshot_count_hi", 8'h0D, 8'hFF);
        step(2);
        chk("rdata_hold", {24'h0, rdata}, 32'hFF);
        wr(8'h01, 8'h01);
        chk("w1c_irq_clear", {31'h0, irq}, 32'h0);

        // ---- W1C on the rollover cycle: set wins ----
        wr(8'h00, 8'h13);
        step(6);
        wr(8'h01, 8'h01);
        chk("w1c_collision_int", {31'h0, irq}, 32'h1);
        wr(8'h01, 8'h01);
        chk("w1c_after_collision", {31'h0, irq}, 32'h0);

        // ---- CTRL write with GO=1 on one-shot rollover: restart ----
        wr(8'h00, 8'h13);
        step(6);
        wr(8'h00, 8'h13);
        rdchk("restart_ctrl", 8'h00, 8'h13);
        rdchk("restart_count_a", 8'h0C, 8'hFA);
        rdchk("restart_count_b", 8'h0C, 8'hFB);
        wr(8'h01, 8'h01);
        chk("restart_irq_cleared", {31'h0, irq}, 32'h0);
        step(2);
        chk("restart_irq_before", {31'h0, irq}, 32'h0);
        step(1);
        chk("restart_irq_again", {31'h0, irq}, 32'h1);
        wr(8'h01, 8'h01);
        rdchk("restart_go_clear", 8'h00, 8'h12);

        // ---- auto-reload with PWM: RELOAD=FFF0, COMPARE=FFF8, CTRL=0F ----
        wr(8'h04, 8'hF0);
        wr(8'h08, 8'hF8);
        wr(8'h09, 8'hFF);
        wr(8'h00, 8'h0F);
        for (int k = 1; k <= 32; k++) begin
            step(1);
            chk($sformatf("pwm_k%0d", k), {30'h0, pwm_out},
                (((k - 1) % 16) < 8) ? 32'h1 : 32'h0);
        end
        chk("auto_irq_masked", {31'h0, irq}, 32'h0);
        rdchk("auto_int_status", 8'h01, 8'h01);
        rdchk("auto_go_stays", 8'h00, 8'h0F);
        wr(8'h00, 8'h0D);
        step(1);
        chk("en0_pwm_low", {30'h0, pwm_out}, 32'h0);
        rdchk("en0_ctrl", 8'h00, 8'h0C);
        wr(8'h01, 8'h01);

        // ---- prescaler PS=3 on channel 1: RELOAD=FFFE ----
        wr(8'h14, 8'hFE);
        wr(8'h15, 8'hFF);
        wr(8'h10, 8'h73);
        for (int i = 0; i < 64; i++) begin
            rd(8'h1C, v);
            if (t_ff < 0 && v == 8'hFF) t_ff = i;
            else if (t_ff >= 0 && t_fe2 < 0 && v == 8'hFE) t_fe2 = i;
        end
        chk("psc_tick_spacing", t_fe2 - t_ff, 32'd8);
        chk("psc_irq", {31'h0, irq}, 32'h1);
        rdchk("psc_ctrl", 8'h10, 8'h72);
        wr(8'h11, 8'h01);
        chk("psc_irq_clear", {31'h0, irq}, 32'h0);

        // ---- independence: ch1 PS=2 RELOAD=FFFE, ch0 PS=0 RELOAD=FFFA ----
        wr(8'h04, 8'hFA);
        wr(8'h10, 8'h53);
        wr(8'h00, 8'h13);
        step(4);
        rdchk("ind_ch1_early", 8'h11, 8'h00);
        step(1);
        rdchk("ind_ch0_early", 8'h01, 8'h00);
        rdchk("ind_ch0_set", 8'h01, 8'h01);
        rdchk("ind_ch1_set", 8'h11, 8'h01);
        rdchk("ind_ch1_ctrl", 8'h10, 8'h52);
        rdchk("ind_ch0_ctrl", 8'h00, 8'h12);
        wr(8'h01, 8'h01);
        wr(8'h11, 8'h01);
        chk("ind_irq_clear", {31'h0, irq}, 32'h0);

        // ---- rst in the middle of an auto/PWM run ----
        wr(8'h04, 8'hF0);
        wr(8'h00, 8'h1F);
        step(1);
        chk("prerst_pwm", {30'h0, pwm_out}, 32'h1);
        step(19);
        chk("prerst_irq", {31'h0, irq}, 32'h1);
        chk("prerst_pwm_late", {30'h0, pwm_out}, 32'h1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("midrst_pwm", {30'h0, pwm_out}, 32'h0);
        chk("midrst_irq", {31'h0, irq}, 32'h0);
        chk("midrst_rdata", {24'h0, rdata}, 32'h0);
        rdchk("midrst_count", 8'h0C, 8'h00);
        rdchk("midrst_ctrl", 8'h00, 8'h00);
        rdchk("midrst_status", 8'h01, 8'h00);
        rdchk("midrst_reload", 8'h04, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
